// File: rtl/phase_pkg.sv
// Shared constants and state type for the phase accumulator.
// Phase words are Q8.10 radians; PI_Q is pi scaled by 2^10 and rounded.
package phase_pkg;

    localparam int PHASE_W  = 19;
    localparam int FRAC_W   = 10;
    localparam int PI_Q     = 3217;
    localparam int TWO_PI_Q = 6434;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/phase_accum_if.sv
// Strobe/data bundle between a phase source and the accumulator.
// The source holds the master modport; the accumulator holds the slave modport.
interface phase_accum_if #(
    parameter int PHASE_W = phase_pkg::PHASE_W,
    parameter int TURN_W  = 8
);

    logic                      sample;
    logic signed [PHASE_W-1:0] delta;
    logic                      load;
    logic signed [PHASE_W-1:0] load_value;
    logic signed [PHASE_W-1:0] out;
    logic                      out_valid;
    logic signed [TURN_W-1:0]  turns;

    modport master (
        output sample, delta, load, load_value,
        input  out, out_valid, turns
    );

    modport slave (
        input  sample, delta, load, load_value,
        output out, out_valid, turns
    );

endinterface

// File: rtl/phase_wrap.sv
// Clamps an increment to one half-turn, adds it to a base phase and folds the
// result back into [-PI_Q, PI_Q) with at most one 2*pi correction.
module phase_wrap #(
    parameter int W = 19
) (
    input  logic signed [W-1:0] base,
    input  logic signed [W-1:0] delta,
    output logic signed [W-1:0] result,
    output logic signed [1:0]   step
);

    import phase_pkg::*;

    localparam logic signed [W-1:0] PI_N      = W'(PI_Q);
    localparam logic signed [W:0]   PI_S      = (W+1)'(PI_Q);
    localparam logic signed [W:0]   TWO_PI_S  = (W+1)'(TWO_PI_Q);

    logic signed [W-1:0] clamped;
    logic signed [W:0]   sum;

    // Both operands lie inside one half-turn, so the extra bit of the sum can
    // never overflow and a single correction always lands back in range.
    always_comb begin
        clamped = delta;
        if (delta >= PI_N) begin
            clamped = PI_N - W'(1);
        end else if (delta < -PI_N) begin
            clamped = -PI_N;
        end

        sum    = {base[W-1], base} + {clamped[W-1], clamped};
        result = W'(sum);
        step   = 2'sd0;
        if (sum >= PI_S) begin
            result = W'(sum - TWO_PI_S);
            step   = 2'sd1;
        end else if (sum < -PI_S) begin
            result = W'(sum + TWO_PI_S);
            step   = -2'sd1;
        end
    end

endmodule

// File: rtl/phase_accum.sv
// Accumulates phase-difference samples into an absolute phase wrapped to
// [-pi, pi) and keeps a saturating count of the net 2*pi wraps.
module phase_accum #(
    parameter int PHASE_W = 19,
    parameter int FRAC_W  = 10,
    parameter int TURN_W  = 8
) (
    input  logic          clock,
    input  logic          reset,
    phase_accum_if.slave  bus
);

    import phase_pkg::*;

    if (FRAC_W >= PHASE_W) begin : g_bad_frac
        $error("phase_accum: FRAC_W must leave integer bits in PHASE_W");
    end

    localparam logic signed [TURN_W-1:0] TURN_MAX = {1'b0, {(TURN_W-1){1'b1}}};
    localparam logic signed [TURN_W-1:0] TURN_MIN = {1'b1, {(TURN_W-1){1'b0}}};

    state_t                    state;
    logic signed [PHASE_W-1:0] out_q;
    logic                      out_valid_q;
    logic signed [TURN_W-1:0]  turns_q;

    logic signed [PHASE_W-1:0] base;
    logic signed [PHASE_W-1:0] acc_next;
    logic signed [PHASE_W-1:0] load_next;
    logic signed [1:0]         acc_step;
    logic signed [1:0]         load_step;

    assign base = (state == RUN) ? out_q : '0;

    phase_wrap #(.W(PHASE_W)) u_acc_wrap (
        .base   (base),
        .delta  (bus.delta),
        .result (acc_next),
        .step   (acc_step)
    );

    // The load path starts from zero, so its step is always 0 and turns
    // restart from the loaded phase.
    phase_wrap #(.W(PHASE_W)) u_load_wrap (
        .base   ('0),
        .delta  (bus.load_value),
        .result (load_next),
        .step   (load_step)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            turns_q     <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (bus.load) begin
                state       <= RUN;
                out_q       <= load_next;
                turns_q     <= TURN_W'(load_step);
                out_valid_q <= 1'b1;
            end else if (bus.sample) begin
                state       <= RUN;
                out_q       <= acc_next;
                out_valid_q <= 1'b1;
                if (acc_step == 2'sd1 && turns_q != TURN_MAX) begin
                    turns_q <= turns_q + TURN_W'(1);
                end else if (acc_step == -2'sd1 && turns_q != TURN_MIN) begin
                    turns_q <= turns_q - TURN_W'(1);
                end
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.turns     = turns_q;

endmodule
